decode_stage_ctrl: RTL and testbench
====================================

// Module: decode_stage_ctrl
// PURPOSE
//  Registered, parametrised successor to the combinational instruction decoder; forms the ID/EX boundary of the pipeline.
//  Decodes the fetched instruction into opcodes, register addresses, immediate and control signals.
//  Adds a valid/ready handshake, stall/flush support and an interrupt-acknowledge FSM with nesting protection.
// PARAMETERS
//  INST_BIT_WIDTH  32  instruction width; opcode fields are the top 8 bits ([W-1:W-4] primary, [W-5:W-8] secondary)
//  REG_ADDR_WIDTH  4   register address width; fields are packed below the opcode fields
//  IMM_WIDTH       16  immediate width; taken from inst[IMM_WIDTH-1:0]
//  IMM_SEXT        1   1 = sign-extend imm to INST_BIT_WIDTH on imm_ext; 0 = zero-extend
// PORTS
//  clk          in   1    clock
//  reset_n      in   1    asynchronous active-low reset
//  in_valid     in   1    fetch stage presents inst
//  in_ready     out  1    stage accepts inst this cycle
//  inst         in   INST_BIT_WIDTH  instruction word
//  out_valid    out  1    registered decode outputs valid
//  out_ready    in   1    execute stage consumes outputs
//  flush        in   1    kill the held decode (taken branch/jump resolved downstream)
//  irq_req      in   1    level interrupt request
//  ie           in   1    interrupt enable (from system register)
//  inta_ack     out  1    one-cycle pulse: interrupt accepted
//  in_isr       out  1    FSM is in IN_ISR
//  fst_opcode   out  4 ; snd_opcode out 5 ; d/s1/s2_reg_addr out REG_ADDR_WIDTH each
//  imm          out  IMM_WIDTH ; imm_ext out INST_BIT_WIDTH
//  reg_wrt_en, imm_sel, is_load, is_store, is_reti, is_rsr, is_wsr  out 1 each
//  mem_out_sel  out  2 ; pc_sel out 2 (00 pc+4, 01 branch, 10 jal, 11 inta/reti)
// BEHAVIOUR
//  Reset: all outputs 0, out_valid=0, FSM=RUN, in_ready=1.
//  Decode table: same opcodes as the current controller. ALU=0000; ALUI=1000; CMP=0010; CMPI=1010; BR=0110; LW=1001; SW=0101; JAL=1011; SYS=1111 (RETI 0001, RSR 0010, WSR 0011).
//  - Branch pc_sel is registered as 00; execute resolves the compare and asserts flush.
//  - JAL imm = inst imm << 2, truncated to IMM_WIDTH.
//  - Unknown opcode: NOP (all zero) with out_valid=1.
//  Latency: 1 cycle from in_valid & in_ready to out_valid.
//  in_ready = (~out_valid | out_ready) & ~inject. Outputs hold while out_valid & ~out_ready (stall).
//  flush: out_valid<=0 next edge. The same-cycle input is also dropped and in_ready=0 that cycle. flush beats stall.
//  FSM states and transitions:
//   - RUN -> INJECT when irq_req & ie.
//   - INJECT: when the slot is free (~out_valid | out_ready), load the INTA bubble. The bubble is all-zero except pc_sel=11 and out_valid=1. Pulse inta_ack; go to IN_ISR. Fetch input is not consumed (inject=1).
//   - IN_ISR: irq_req ignored. Decoding RETI sets is_reti and pc_sel=11. On RETI handshake out (out_valid & out_ready) go to RUN.
//   - flush in INJECT: bubble still issued next free slot (interrupt is never lost). flush in IN_ISR: state kept.
//   - irq_req dropping in INJECT before issue: return to RUN, no ack.
//  Reset mid-operation: immediate return to reset values; a pending interrupt is not remembered.
// TESTING
//  - ALU 0x0123_4000 in, out_ready=1 -> next cycle fst=0000, snd=00001, d=2, s1=3, s2=4, reg_wrt_en=1, out_valid=1.
//  - LW 0x9120_FFFC with IMM_SEXT=1 -> imm=FFFC, imm_ext=FFFF_FFFC, is_load=1, mem_out_sel=01.
//  - out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0; release -> next inst decoded 1 cycle later.
//  - irq_req=1, ie=1 -> bubble pc_sel=11, inta_ack pulse, in_isr=1. Second irq_req ignored until RETI 0xF100_0000 exits; then in_isr=0.
//  - flush while stalled holding SW -> out_valid=0 next cycle, is_store=0; INJECT+flush still yields inta_ack.
//  - reset_n low during IN_ISR -> all outputs 0 asynchronously, in_isr=0.

Source files
------------

// File: rtl/decode_stage_ctrl.sv
// decode_stage_ctrl
//   Registered decode stage forming the ID/EX pipeline boundary. Each accepted
//   instruction is decoded into opcode fields, register addresses, an immediate
//   and control strobes. The result is held in an output register until the
//   execute stage takes it.
//   A small FSM injects an interrupt-acknowledge bubble into the stream. It
//   blocks nested interrupts until the RETI that ends the handler has left
//   this stage.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
//   high. in_valid/inst must stay stable until accepted. out_valid and all
//   decode outputs hold while out_valid & ~out_ready.
//
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   in_valid, in_ready, inst fetch-side handshake and instruction word
//   out_valid, out_ready     execute-side handshake
//   flush                    kill the held decode and drop this cycle's input
//   irq_req, ie              level interrupt request, interrupt enable
//   inta_ack                 one-cycle pulse when the INTA bubble is issued
//   in_isr                   interrupt handler active (FSM in IN_ISR)
//   fst_opcode .. pc_sel     registered decode outputs
//   dbg_state                FSM state (0 RUN, 1 INJECT, 2 IN_ISR)
module decode_stage_ctrl #(
  parameter int INST_BIT_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int IMM_WIDTH      = 16,
  parameter bit IMM_SEXT       = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INST_BIT_WIDTH-1:0] inst,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      flush,
  input  logic                      irq_req,
  input  logic                      ie,
  output logic                      inta_ack,
  output logic                      in_isr,
  output logic [3:0]                fst_opcode,
  output logic [4:0]                snd_opcode,
  output logic [REG_ADDR_WIDTH-1:0] d_reg_addr,
  output logic [REG_ADDR_WIDTH-1:0] s1_reg_addr,
  output logic [REG_ADDR_WIDTH-1:0] s2_reg_addr,
  output logic [IMM_WIDTH-1:0]      imm,
  output logic [INST_BIT_WIDTH-1:0] imm_ext,
  output logic                      reg_wrt_en,
  output logic                      imm_sel,
  output logic                      is_load,
  output logic                      is_store,
  output logic                      is_reti,
  output logic                      is_rsr,
  output logic                      is_wsr,
  output logic [1:0]                mem_out_sel,
  output logic [1:0]                pc_sel,
  output logic [1:0]                dbg_state
);

  localparam int W = INST_BIT_WIDTH;
  localparam int R = REG_ADDR_WIDTH;
  localparam int I = IMM_WIDTH;

  typedef enum logic [1:0] {RUN = 2'd0, INJECT = 2'd1, IN_ISR = 2'd2} state_t;

  typedef struct packed {
    logic [3:0]   fst;
    logic [4:0]   snd;
    logic [R-1:0] d;
    logic [R-1:0] s1;
    logic [R-1:0] s2;
    logic [I-1:0] imm;
    logic [W-1:0] imm_ext;
    logic         reg_wrt_en;
    logic         imm_sel;
    logic         is_load;
    logic         is_store;
    logic         is_reti;
    logic         is_rsr;
    logic         is_wsr;
    logic [1:0]   mem_out_sel;
    logic [1:0]   pc_sel;
  } dec_t;

  state_t state, state_nxt;
  dec_t   dec_d, dec_q, bubble;
  logic   slot_free, inject, accept, issue_bubble, reti_done, known;
  logic [3:0]   op1, op2;
  logic [I-1:0] imm_d;

  // Control and handshake
  assign slot_free    = ~out_valid | out_ready;
  assign inject       = (state == INJECT);
  assign in_ready     = slot_free & ~inject & ~flush;
  assign accept       = in_valid & in_ready;
  // A flush in INJECT frees the slot; the bubble goes out on a later cycle.
  assign issue_bubble = inject & irq_req & slot_free & ~flush;
  assign reti_done    = (state == IN_ISR) & out_valid & out_ready & dec_q.is_reti & ~flush;

  // Combinational decode of the presented instruction
  always_comb begin
    op1   = inst[W-1 -: 4];
    op2   = inst[W-5 -: 4];
    imm_d = inst[I-1:0];
    known = 1'b1;
    dec_d = '0;
    case (op1)
      4'b0000, 4'b0010: dec_d.reg_wrt_en = 1'b1;                   // ALU, CMP
      4'b1000, 4'b1010: begin                                       // ALUI, CMPI
        dec_d.reg_wrt_en = 1'b1;
        dec_d.imm_sel    = 1'b1;
      end
      4'b0110: dec_d.imm_sel = 1'b1;   // BR: pc+4 here, execute flushes if taken
      4'b1001: begin                                                // LW
        dec_d.reg_wrt_en  = 1'b1;
        dec_d.imm_sel     = 1'b1;
        dec_d.is_load     = 1'b1;
        dec_d.mem_out_sel = 2'b01;
      end
      4'b0101: begin                                                // SW
        dec_d.imm_sel  = 1'b1;
        dec_d.is_store = 1'b1;
      end
      4'b1011: begin                   // JAL: word offset, link value written back
        dec_d.reg_wrt_en  = 1'b1;
        dec_d.imm_sel     = 1'b1;
        dec_d.mem_out_sel = 2'b10;
        dec_d.pc_sel      = 2'b10;
        imm_d             = {inst[I-3:0], 2'b00};
      end
      4'b1111: begin                                                // SYS
        case (op2)
          4'b0001: begin
            dec_d.is_reti = 1'b1;
            dec_d.pc_sel  = 2'b11;
          end
          4'b0010: begin
            dec_d.is_rsr      = 1'b1;
            dec_d.reg_wrt_en  = 1'b1;
            dec_d.mem_out_sel = 2'b11;
          end
          4'b0011: dec_d.is_wsr = 1'b1;
          default: known = 1'b0;
        endcase
      end
      default: known = 1'b0;
    endcase
    if (known) begin
      dec_d.fst     = op1;
      dec_d.snd     = {1'b0, op2};
      dec_d.d       = inst[W-9 -: R];
      dec_d.s1      = inst[W-9-R -: R];
      dec_d.s2      = inst[W-9-2*R -: R];
      dec_d.imm     = imm_d;
      dec_d.imm_ext = IMM_SEXT ? {{(W-I){imm_d[I-1]}}, imm_d} : {{(W-I){1'b0}}, imm_d};
    end else begin
      dec_d = '0;                      // unknown encoding issues as a NOP
    end
  end

  always_comb begin
    bubble        = '0;
    bubble.pc_sel = 2'b11;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (irq_req & ie) state_nxt = INJECT;
      INJECT:  if (!irq_req) state_nxt = RUN;
               else if (issue_bubble) state_nxt = IN_ISR;
      IN_ISR:  if (reti_done) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_nxt;
  end

  // Output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_q     <= '0;
      out_valid <= 1'b0;
      inta_ack  <= 1'b0;
    end else begin
      inta_ack <= issue_bubble;
      if (flush) begin
        dec_q     <= '0;
        out_valid <= 1'b0;
      end else if (issue_bubble) begin
        dec_q     <= bubble;
        out_valid <= 1'b1;
      end else if (accept) begin
        dec_q     <= dec_d;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign in_isr      = (state == IN_ISR);
  assign dbg_state   = state;
  assign fst_opcode  = dec_q.fst;
  assign snd_opcode  = dec_q.snd;
  assign d_reg_addr  = dec_q.d;
  assign s1_reg_addr = dec_q.s1;
  assign s2_reg_addr = dec_q.s2;
  assign imm         = dec_q.imm;
  assign imm_ext     = dec_q.imm_ext;
  assign reg_wrt_en  = dec_q.reg_wrt_en;
  assign imm_sel     = dec_q.imm_sel;
  assign is_load     = dec_q.is_load;
  assign is_store    = dec_q.is_store;
  assign is_reti     = dec_q.is_reti;
  assign is_rsr      = dec_q.is_rsr;
  assign is_wsr      = dec_q.is_wsr;
  assign mem_out_sel = dec_q.mem_out_sel;
  assign pc_sel      = dec_q.pc_sel;

endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Testbench for decode_stage_ctrl (default parameters: 32/4/16, sign-extend).
module tb_decode_stage_ctrl;

  localparam int VW = 80;

  logic        clk = 1'b0;
  logic        reset_n, in_valid, out_ready, flush, irq_req, ie;
  logic [31:0] inst;
  logic        in_ready, out_valid, inta_ack, in_isr;
  logic [3:0]  fst_opcode;
  logic [4:0]  snd_opcode;
  logic [3:0]  d_reg_addr, s1_reg_addr, s2_reg_addr;
  logic [15:0] imm;
  logic [31:0] imm_ext;
  logic        reg_wrt_en, imm_sel, is_load, is_store, is_reti, is_rsr, is_wsr;
  logic [1:0]  mem_out_sel, pc_sel, dbg_state;

  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] got_vec;
  int n_chk = 0;
  int n_err = 0;
  int ack_cnt = 0;
  int acks0;

  decode_stage_ctrl dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .irq_req(irq_req), .ie(ie), .inta_ack(inta_ack), .in_isr(in_isr),
    .fst_opcode(fst_opcode), .snd_opcode(snd_opcode), .d_reg_addr(d_reg_addr),
    .s1_reg_addr(s1_reg_addr), .s2_reg_addr(s2_reg_addr), .imm(imm),
    .imm_ext(imm_ext), .reg_wrt_en(reg_wrt_en), .imm_sel(imm_sel),
    .is_load(is_load), .is_store(is_store), .is_reti(is_reti), .is_rsr(is_rsr),
    .is_wsr(is_wsr), .mem_out_sel(mem_out_sel), .pc_sel(pc_sel),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  assign got_vec = {fst_opcode, snd_opcode, d_reg_addr, s1_reg_addr, s2_reg_addr,
                    imm, imm_ext, reg_wrt_en, imm_sel, is_load, is_store, is_reti,
                    is_rsr, is_wsr, mem_out_sel, pc_sel};

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ctl = {reg_wrt_en, imm_sel, is_load, is_store, is_reti, is_rsr, is_wsr}
  function automatic logic [VW-1:0] pk(input logic [3:0] f, input logic [4:0] s,
      input logic [3:0] d, input logic [3:0] a, input logic [3:0] b,
      input logic [15:0] im, input logic [31:0] ex, input logic [6:0] ctl,
      input logic [1:0] mo, input logic [1:0] pc);
    return {f, s, d, a, b, im, ex, ctl, mo, pc};
  endfunction

  // Reference decode
  function automatic logic [VW-1:0] model(input logic [31:0] x);
    logic [3:0]  op, sub;
    logic [15:0] im;
    logic [6:0]  ctl;
    logic [1:0]  mo, pc;
    bit          known;
    op = x[31:28]; sub = x[27:24]; im = x[15:0];
    ctl = 7'b0; mo = 2'b00; pc = 2'b00; known = 1'b1;
    case (op)
      4'h0, 4'h2: ctl = 7'b1000000;
      4'h8, 4'hA: ctl = 7'b1100000;
      4'h6:       ctl = 7'b0100000;
      4'h9: begin ctl = 7'b1110000; mo = 2'b01; end
      4'h5:       ctl = 7'b0101000;
      4'hB: begin ctl = 7'b1100000; mo = 2'b10; pc = 2'b10; im = {x[13:0], 2'b00}; end
      4'hF: begin
        if (sub == 4'h1)      begin ctl = 7'b0000100; pc = 2'b11; end
        else if (sub == 4'h2) begin ctl = 7'b1000010; mo = 2'b11; end
        else if (sub == 4'h3) ctl = 7'b0000001;
        else known = 1'b0;
      end
      default: known = 1'b0;
    endcase
    if (!known) return '0;
    return pk(op, {1'b0, sub}, x[23:20], x[19:16], x[15:12], im,
              {{16{im[15]}}, im}, ctl, mo, pc);
  endfunction

  localparam logic [VW-1:0] BUBBLE = 80'd3;

  // Scoreboard: compare every output handshake against the expected queue
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", got_vec, '0);
      else                   chk("out", got_vec, exp_q.pop_front());
    end
    if (reset_n && inta_ack) ack_cnt++;
  end

  // Driver tasks
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input bit push, input bit rnd);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    inst = w;
    if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      if (rnd) out_ready = 1'b1;
    end
    if (!ok) begin
      chk("send_timeout", '0, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (push) exp_q.push_back(model(w));
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_ack(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (inta_ack) begin seen = 1'b1; break; end
    end
    chk(tag, VW'(seen), 1);
    chk({tag, "_in_isr"}, VW'(in_isr), 1);
    @(negedge clk);
    chk({tag, "_pulse"}, VW'(inta_ack), 0);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    irq_req = 1'b0; ie = 1'b1; inst = '0;
    #22;
    chk("rst_outputs", got_vec, '0);
    chk("rst_out_valid", VW'(out_valid), 0);
    chk("rst_in_ready", VW'(in_ready), 1);
    chk("rst_in_isr", VW'(in_isr), 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // ALU and LW directed, one-cycle latency
    send(32'h0123_4000, 1'b0, 1'b0);
    exp_q.push_back(pk(4'h0, 5'h01, 4'h2, 4'h3, 4'h4, 16'h4000, 32'h0000_4000,
                       7'b1000000, 2'b00, 2'b00));
    @(negedge clk);
    chk("alu_latency", VW'(out_valid), 1);
    send(32'h9120_FFFC, 1'b0, 1'b0);
    exp_q.push_back(pk(4'h9, 5'h01, 4'h2, 4'h0, 4'hF, 16'hFFFC, 32'hFFFF_FFFC,
                       7'b1110000, 2'b01, 2'b00));
    cycles(2);

    // Stall: outputs held, in_ready low, next instruction follows release
    out_ready = 1'b0;
    send(32'h8A5C_1234, 1'b1, 1'b0);
    @(posedge clk); #1 in_valid = 1'b1; inst = 32'hB300_2001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", VW'(in_ready), 0);
      chk("stall_hold", got_vec, pk(4'h8, 5'h0A, 4'h5, 4'hC, 4'h1, 16'h1234,
                                    32'h0000_1234, 7'b1100000, 2'b00, 2'b00));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", VW'(in_ready), 1);
    @(posedge clk);
    exp_q.push_back(model(32'hB300_2001));
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("release_latency", VW'(out_valid), 1);

    // Random traffic with random back-pressure
    for (int n = 0; n < 40; n++) begin
      logic [3:0] ops [11];
      ops = '{4'h0, 4'h8, 4'h2, 4'hA, 4'h6, 4'h9, 4'h5, 4'hB, 4'hF, 4'h3, 4'hC};
      send({ops[$urandom_range(0, 10)], 4'($urandom_range(0, 4)), 24'($urandom)},
           1'b1, 1'b1);
    end
    out_ready = 1'b1;
    cycles(3);

    // Interrupt: bubble, ack pulse, nesting blocked until RETI leaves
    acks0 = ack_cnt;
    irq_req = 1'b1; ie = 1'b1;
    exp_q.push_back(BUBBLE);
    wait_ack("irq_ack");
    send(32'h0456_7000, 1'b1, 1'b0);
    cycles(4);
    chk("nest_ack_count", VW'(ack_cnt - acks0), 1);
    chk("nest_in_isr", VW'(in_isr), 1);
    irq_req = 1'b0;
    send(32'hF100_0000, 1'b0, 1'b0);
    exp_q.push_back(pk(4'hF, 5'h01, 4'h0, 4'h0, 4'h0, 16'h0, 32'h0,
                       7'b0000100, 2'b00, 2'b11));
    @(negedge clk); @(negedge clk);
    chk("reti_exit", VW'(in_isr), 0);
    cycles(2);

    // Flush while stalled on SW; the same-cycle input is dropped
    out_ready = 1'b0;
    send(32'h5678_8004, 1'b0, 1'b0);
    @(negedge clk);
    chk("sw_held_store", VW'(is_store), 1);
    @(posedge clk); #1 flush = 1'b1; in_valid = 1'b1; inst = 32'h0123_4000;
    @(negedge clk);
    chk("flush_in_ready", VW'(in_ready), 0);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", VW'(out_valid), 0);
    chk("flush_is_store", VW'(is_store), 0);

    // Flush during INJECT: the interrupt is still acknowledged
    send(32'h0111_1000, 1'b0, 1'b0);
    acks0 = ack_cnt;
    irq_req = 1'b1;
    cycles(3);
    chk("inject_blocked", VW'(ack_cnt - acks0), 0);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0; out_ready = 1'b1;
    exp_q.push_back(BUBBLE);
    wait_ack("inject_flush_ack");
    irq_req = 1'b0;
    send(32'hF100_0000, 1'b1, 1'b0);
    @(negedge clk); @(negedge clk);
    chk("reti_exit2", VW'(in_isr), 0);

    // irq_req drops in INJECT before the slot frees: no ack
    out_ready = 1'b0;
    send(32'h2ABC_0000, 1'b1, 1'b0);
    acks0 = ack_cnt;
    irq_req = 1'b1;
    cycles(2);
    irq_req = 1'b0;
    cycles(2);
    chk("drop_state_run", VW'(dbg_state), 0);
    out_ready = 1'b1;
    cycles(3);
    chk("drop_no_ack", VW'(ack_cnt - acks0), 0);

    // Asynchronous reset during IN_ISR
    irq_req = 1'b1;
    exp_q.push_back(BUBBLE);
    wait_ack("pre_reset_ack");
    out_ready = 1'b0;
    send(32'h9120_0010, 1'b0, 1'b0);
    @(posedge clk); #3 reset_n = 1'b0;
    #1;
    chk("async_rst_outputs", got_vec, '0);
    chk("async_rst_out_valid", VW'(out_valid), 0);
    chk("async_rst_in_isr", VW'(in_isr), 0);
    chk("async_rst_in_ready", VW'(in_ready), 1);
    irq_req = 1'b0;
    exp_q.delete();
    acks0 = ack_cnt;
    @(posedge clk); #1 reset_n = 1'b1; out_ready = 1'b1;
    cycles(4);
    chk("post_rst_in_isr", VW'(in_isr), 0);
    chk("post_rst_no_ack", VW'(ack_cnt - acks0), 0);

    chk("queue_drained", VW'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
